// File: rtl/mbist_pkg.sv
// Shared types for the MBIST repair mux: FSM states, repair-table entry, mask helper.
package mbist_pkg;

  // Width of the repair-table address field; the top's BIST_ADDR_WD must match.
  localparam int MBIST_ADDR_WD = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ALLOC,
    ST_FULL
  } mbist_state_e;

  typedef struct packed {
    logic                     valid;
    logic [MBIST_ADDR_WD-1:0] addr;
  } repair_entry_t;

  function automatic logic [63:0] mask_ones(input int unsigned n);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < 64; i++)
      if (i < n) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/mbist_repair_cam.sv
// Repair table: CNT entries, two parallel lookups (lowest index wins), one write port.
module mbist_repair_cam
  import mbist_pkg::*;
#(
  parameter int CNT = 4,
  parameter int CW  = $clog2(CNT+1),
  parameter int IW  = (CNT > 1) ? $clog2(CNT) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     wr_en_i,
  input  logic [CW-1:0]            wr_idx_i,
  input  logic [MBIST_ADDR_WD-1:0] wr_addr_i,
  input  logic [MBIST_ADDR_WD-1:0] lk_a_addr_i,
  output logic                     lk_a_hit_o,
  output logic [IW-1:0]            lk_a_idx_o,
  input  logic [MBIST_ADDR_WD-1:0] lk_b_addr_i,
  output logic                     lk_b_hit_o
);

  repair_entry_t tbl_q [CNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CNT; i++) tbl_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < CNT; i++) tbl_q[i] <= '0;
    end else if (wr_en_i) begin
      for (int i = 0; i < CNT; i++)
        if (wr_idx_i == CW'(i)) tbl_q[i] <= '{valid: 1'b1, addr: wr_addr_i};
    end
  end

  // Scan high to low so the lowest matching index is what remains.
  always_comb begin
    lk_a_hit_o = 1'b0;
    lk_a_idx_o = '0;
    lk_b_hit_o = 1'b0;
    for (int i = CNT-1; i >= 0; i--) begin
      if (tbl_q[i].valid && tbl_q[i].addr == lk_a_addr_i) begin
        lk_a_hit_o = 1'b1;
        lk_a_idx_o = IW'(i);
      end
      if (tbl_q[i].valid && tbl_q[i].addr == lk_b_addr_i) lk_b_hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/mbist_repair_mux.sv
// BIST/functional SRAM mux with N-entry row repair and error-capture allocation FSM.
// Optional MBIST_REPAIR_PIPE_EN registers the memory-side outputs (1 cycle latency).
module mbist_repair_mux
  import mbist_pkg::*;
#(
  parameter int                      BIST_ADDR_WD           = MBIST_ADDR_WD,
  parameter int                      BIST_DATA_WD           = 32,
  parameter int                      BIST_REPAIR_CNT        = 4,
  parameter logic [BIST_ADDR_WD-1:0] BIST_REPAIR_ADDR_START = 9'h1FC,
  parameter int                      BIST_CNT_WD            = $clog2(BIST_REPAIR_CNT+1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      bist_en,
  input  logic [BIST_ADDR_WD-1:0]   bist_addr,
  input  logic [BIST_DATA_WD-1:0]   bist_wdata,
  input  logic                      bist_wr,
  input  logic                      bist_rd,
  input  logic                      bist_error,
  input  logic [BIST_ADDR_WD-1:0]   bist_error_addr,
  input  logic                      bist_clear,
  output logic                      bist_correct,
  output logic                      bist_repair_fail,
  output logic [BIST_CNT_WD-1:0]    bist_repair_cnt,
  input  logic                      func_cen,
  input  logic                      func_web,
  input  logic [BIST_DATA_WD/8-1:0] func_mask,
  input  logic [BIST_ADDR_WD-1:0]   func_addr,
  input  logic [BIST_DATA_WD-1:0]   func_din,
  output logic [BIST_DATA_WD-1:0]   func_dout,
  output logic                      mem_cen,
  output logic                      mem_web,
  output logic [BIST_DATA_WD/8-1:0] mem_mask,
  output logic [BIST_ADDR_WD-1:0]   mem_addr,
  output logic [BIST_DATA_WD-1:0]   mem_din,
  input  logic [BIST_DATA_WD-1:0]   mem_dout
);

  localparam int MW = BIST_DATA_WD/8;
  localparam int IW = (BIST_REPAIR_CNT > 1) ? $clog2(BIST_REPAIR_CNT) : 1;
  localparam logic [BIST_ADDR_WD-1:0] SPARE_LAST =
    BIST_ADDR_WD'(BIST_REPAIR_ADDR_START + BIST_ADDR_WD'(BIST_REPAIR_CNT - 1));

  mbist_state_e            state_q, state_d;
  logic [BIST_ADDR_WD-1:0] err_addr_q, err_addr_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [BIST_ADDR_WD-1:0] pend_addr_q, pend_addr_d;
  logic [BIST_CNT_WD-1:0]  cnt_q, cnt_d;
  logic                    fail_q, fail_d;
  logic                    correct_q, correct_d;
  logic                    alloc_we, err_in;

  logic                    mux_cen, mux_web;
  logic [MW-1:0]           mux_mask;
  logic [BIST_ADDR_WD-1:0] laddr, remap_addr;
  logic [BIST_DATA_WD-1:0] mux_din;
  logic                    lk_hit, chk_hit;
  logic [IW-1:0]           lk_idx;

  always_comb begin
    if (bist_en) begin
      mux_cen  = !(bist_rd | bist_wr);
      mux_web  = !bist_wr;
      mux_mask = MW'(mask_ones(MW));
      mux_din  = bist_wdata;
      laddr    = bist_addr;
    end else begin
      mux_cen  = func_cen;
      mux_web  = func_web;
      mux_mask = func_mask;
      mux_din  = func_din;
      laddr    = func_addr;
    end
  end

  mbist_repair_cam #(.CNT(BIST_REPAIR_CNT), .CW(BIST_CNT_WD), .IW(IW)) u_cam (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (bist_clear),
    .wr_en_i     (alloc_we),
    .wr_idx_i    (cnt_q),
    .wr_addr_i   (err_addr_q),
    .lk_a_addr_i (laddr),
    .lk_a_hit_o  (lk_hit),
    .lk_a_idx_o  (lk_idx),
    .lk_b_addr_i (err_addr_q),
    .lk_b_hit_o  (chk_hit)
  );

  assign remap_addr = lk_hit ? BIST_ADDR_WD'(BIST_REPAIR_ADDR_START + BIST_ADDR_WD'(lk_idx))
                             : laddr;
  assign err_in     = bist_error & bist_en;

  always_comb begin
    state_d     = state_q;
    err_addr_d  = err_addr_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    cnt_d       = cnt_q;
    fail_d      = fail_q;
    alloc_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          // Drain the held error; a fresh one takes its slot.
          err_addr_d  = pend_addr_q;
          pend_vld_d  = err_in;
          pend_addr_d = err_in ? bist_error_addr : pend_addr_q;
          state_d     = ST_CHECK;
        end else if (err_in) begin
          err_addr_d = bist_error_addr;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (chk_hit) state_d = ST_IDLE;
        else if ((err_addr_q >= BIST_REPAIR_ADDR_START && err_addr_q <= SPARE_LAST) ||
                 cnt_q == BIST_CNT_WD'(BIST_REPAIR_CNT)) begin
          fail_d  = 1'b1;
          state_d = ST_FULL;
        end else state_d = ST_ALLOC;
      end
      ST_ALLOC: begin
        alloc_we = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: ;
    endcase
    // Errors landing mid-operation: hold one, overflow is unrepairable.
    if ((state_q == ST_CHECK || state_q == ST_ALLOC) && err_in) begin
      if (!pend_vld_q) begin
        pend_vld_d  = 1'b1;
        pend_addr_d = bist_error_addr;
      end else begin
        pend_vld_d = 1'b0;
        fail_d     = 1'b1;
        state_d    = ST_FULL;
      end
    end
    if (bist_clear) begin
      state_d    = ST_IDLE;
      pend_vld_d = 1'b0;
      cnt_d      = '0;
      fail_d     = 1'b0;
      alloc_we   = 1'b0;
    end
    correct_d = (cnt_d != '0) && !fail_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      err_addr_q  <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      cnt_q       <= '0;
      fail_q      <= 1'b0;
      correct_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_addr_q  <= err_addr_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      cnt_q       <= cnt_d;
      fail_q      <= fail_d;
      correct_q   <= correct_d;
    end
  end

  assign bist_correct     = correct_q;
  assign bist_repair_fail = fail_q;
  assign bist_repair_cnt  = cnt_q;
  assign func_dout        = mem_dout;

`ifdef MBIST_REPAIR_PIPE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cen  <= 1'b1;
      mem_web  <= 1'b1;
      mem_mask <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      mem_cen  <= mux_cen;
      mem_web  <= mux_web;
      mem_mask <= mux_mask;
      mem_addr <= remap_addr;
      mem_din  <= mux_din;
    end
  end
`else
  assign mem_cen  = mux_cen;
  assign mem_web  = mux_web;
  assign mem_mask = mux_mask;
  assign mem_addr = remap_addr;
  assign mem_din  = mux_din;
`endif

endmodule

// File: tb/tb_mbist_repair_mux.sv
// Directed bench for mbist_repair_mux with a queue scoreboard of expected values.
module tb_mbist_repair_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bist_en, bist_wr, bist_rd, bist_error, bist_clear;
  logic [8:0]  bist_addr, bist_error_addr, func_addr, mem_addr;
  logic [31:0] bist_wdata, func_din, func_dout, mem_din, mem_dout;
  logic        bist_correct, bist_repair_fail;
  logic [2:0]  bist_repair_cnt;
  logic        func_cen, func_web, mem_cen, mem_web;
  logic [3:0]  func_mask, mem_mask;

  int checks = 0;
  int failures = 0;
  string       tag_q[$];
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mbist_repair_mux dut (
    .clk(clk), .rst_n(rst_n), .bist_en(bist_en), .bist_addr(bist_addr),
    .bist_wdata(bist_wdata), .bist_wr(bist_wr), .bist_rd(bist_rd),
    .bist_error(bist_error), .bist_error_addr(bist_error_addr), .bist_clear(bist_clear),
    .bist_correct(bist_correct), .bist_repair_fail(bist_repair_fail),
    .bist_repair_cnt(bist_repair_cnt), .func_cen(func_cen), .func_web(func_web),
    .func_mask(func_mask), .func_addr(func_addr), .func_din(func_din),
    .func_dout(func_dout), .mem_cen(mem_cen), .mem_web(mem_web), .mem_mask(mem_mask),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string t, input logic [63:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    string t;
    logic [63:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty: observed %0h required an expected entry", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  // Memory-side outputs lag one clock in the pipelined build.
  task automatic settle_mem();
`ifdef MBIST_REPAIR_PIPE_EN
    tick();
`else
    #1;
`endif
  endtask

  task automatic status_chk(input string t, input int cnt, input bit fail, input bit corr);
    push({t, "_cnt"}, 64'(cnt));
    push({t, "_fail"}, 64'(fail));
    push({t, "_correct"}, 64'(corr));
    #1;
    pop_chk(64'(bist_repair_cnt));
    pop_chk(64'(bist_repair_fail));
    pop_chk(64'(bist_correct));
  endtask

  task automatic addr_chk(input string t, input logic [8:0] la, input logic [8:0] exp);
    bist_addr = la;
    push(t, 64'(exp));
    settle_mem();
    pop_chk(64'(mem_addr));
  endtask

  task automatic err_pulse(input logic [8:0] a, input int wait_cyc);
    bist_error = 1'b1;
    bist_error_addr = a;
    tick();
    bist_error = 1'b0;
    tick(wait_cyc);
  endtask

  task automatic clear_tbl();
    bist_clear = 1'b1;
    tick();
    bist_clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; bist_en = 0; bist_wr = 0; bist_rd = 0; bist_error = 0; bist_clear = 0;
    bist_addr = '0; bist_error_addr = '0; bist_wdata = '0;
    func_cen = 1; func_web = 1; func_mask = '0; func_addr = '0; func_din = '0;
    mem_dout = 32'hDEAD_BEEF;
    tick(2);
    status_chk("reset", 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // BIST write passes through unremapped.
    bist_en = 1; bist_wr = 1; bist_addr = 9'h010; bist_wdata = 32'hA5A5_0101;
    push("bist_cen", 0); push("bist_web", 0); push("bist_mask", 64'h F);
    push("bist_addr", 64'h010); push("bist_din", 64'hA5A5_0101);
    settle_mem();
    pop_chk(64'(mem_cen)); pop_chk(64'(mem_web)); pop_chk(64'(mem_mask));
    pop_chk(64'(mem_addr)); pop_chk(64'(mem_din));
    push("func_dout", 64'hDEAD_BEEF);
    #1 pop_chk(64'(func_dout));
    status_chk("idle", 0, 0, 0);
    bist_wr = 0; bist_rd = 1;
    push("bist_rd_cen", 0); push("bist_rd_web", 1);
    settle_mem();
    pop_chk(64'(mem_cen)); pop_chk(64'(mem_web));

    // Single repair: visible two clocks after the capturing edge.
    bist_error = 1; bist_error_addr = 9'h023;
    tick();
    bist_error = 0;
    tick();
    status_chk("lat_early", 0, 0, 0);
    tick();
    status_chk("lat_done", 1, 0, 1);
    addr_chk("remap_023", 9'h023, 9'h1FC);
    err_pulse(9'h023, 4);
    status_chk("repeat_023", 1, 0, 1);

    // Back-to-back errors through the pending slot.
    clear_tbl();
    bist_error = 1; bist_error_addr = 9'h001; tick();
    bist_error_addr = 9'h002; tick();
    bist_error = 0; tick(5);
    status_chk("b2b", 2, 0, 1);
    addr_chk("b2b_001", 9'h001, 9'h1FC);
    addr_chk("b2b_002", 9'h002, 9'h1FD);

    // Third error while pending is occupied.
    clear_tbl();
    bist_error = 1; bist_error_addr = 9'h001; tick();
    bist_error_addr = 9'h002; tick();
    bist_error_addr = 9'h003; tick();
    bist_error = 0; tick(3);
    status_chk("overflow", 1, 1, 0);

    // Fill all spares, fifth distinct error is unrepairable.
    clear_tbl();
    for (int i = 0; i < 4; i++) err_pulse(9'h030 + 9'(i), 3);
    status_chk("fill4", 4, 0, 1);
    addr_chk("fill_033", 9'h033, 9'h1FF);
    err_pulse(9'h034, 3);
    status_chk("fifth", 4, 1, 0);
    err_pulse(9'h035, 3);
    status_chk("full_absorb", 4, 1, 0);
    clear_tbl();
    status_chk("cleared", 0, 0, 0);
    addr_chk("clr_033", 9'h033, 9'h033);

    // Ignored errors with bist_en low, spare-row failure, retained table.
    err_pulse(9'h023, 3);
    bist_en = 0;
    err_pulse(9'h040, 3);
    status_chk("ignored", 1, 0, 1);
    bist_en = 1;
    err_pulse(9'h1FD, 3);
    status_chk("spare_fail", 1, 1, 0);
    bist_en = 0; bist_rd = 0;
    func_cen = 0; func_web = 0; func_mask = 4'h5; func_addr = 9'h023; func_din = 32'h1234_5678;
    push("func_addr", 64'h1FC); push("func_mask", 64'h5); push("func_cen", 0);
    push("func_din", 64'h1234_5678);
    settle_mem();
    pop_chk(64'(mem_addr)); pop_chk(64'(mem_mask)); pop_chk(64'(mem_cen)); pop_chk(64'(mem_din));

`ifdef MBIST_REPAIR_PIPE_EN
    func_addr = 9'h011;
    push("pipe_hold", 64'h1FC);
    #1 pop_chk(64'(mem_addr));
    push("pipe_lag", 64'h011);
    tick();
    pop_chk(64'(mem_addr));
`endif

    // Reset asserted while an allocation is in flight.
    bist_en = 1; func_cen = 1; func_web = 1;
    clear_tbl();
    bist_error = 1; bist_error_addr = 9'h050; tick();
    bist_error = 0; tick();
    rst_n = 1'b0;
    status_chk("rst_alloc", 0, 0, 0);
`ifdef MBIST_REPAIR_PIPE_EN
    push("rst_pipe_cen", 1); push("rst_pipe_addr", 0);
    #1 pop_chk(64'(mem_cen)); pop_chk(64'(mem_addr));
`else
    addr_chk("rst_050", 9'h050, 9'h050);
`endif
    tick();
    rst_n = 1'b1;
    tick(3);
    status_chk("post_rst", 0, 0, 0);
    addr_chk("post_rst_050", 9'h050, 9'h050);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
